// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// buffer geometry and the decoder-length sanity check.
package instr_fetch_seq_pkg;

  localparam int BUF_BYTES = 16;
  localparam int WIN_BYTES = 12;
  localparam int MAX_LEN   = 12;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ISSUE,
    ST_DRAIN,
    ST_FAULT,
    ST_END
  } fetch_state_e;

  // A length is usable only if it is non-zero, fits the window and is fully buffered.
  function automatic logic len_valid(input logic [3:0] len, input logic [CNT_W-1:0] count);
    return (len != 4'd0) && (len <= 4'(MAX_LEN)) && ({1'b0, len} <= count);
  endfunction

endpackage

// File: rtl/instr_fetch_seq_byte_shifter.sv
// Byte-granular buffer update: drop consumed bytes from the bottom, then
// drop an incoming 32-bit word in at the first free byte slot.
module fetch_byte_shifter
  import instr_fetch_seq_pkg::*;
(
  input  logic [8*BUF_BYTES-1:0] buf_i,
  input  logic [CNT_W-1:0]       shamt_i,
  input  logic                   wr_en_i,
  input  logic [CNT_W-1:0]       wr_idx_i,
  input  logic [31:0]            word_i,
  output logic [8*BUF_BYTES-1:0] buf_o
);

  logic [8*BUF_BYTES-1:0] shifted;
  logic [CNT_W-1:0]       off;

  always_comb begin
    shifted = buf_i >> {shamt_i, 3'b000};
    buf_o   = shifted;
    off     = '0;
    for (int k = 0; k < BUF_BYTES; k++) begin
      off = CNT_W'(k) - wr_idx_i;
      if (wr_en_i && (CNT_W'(k) >= wr_idx_i) && (off < CNT_W'(4))) begin
        buf_o[8*k +: 8] = word_i[8*off[1:0] +: 8];
      end
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: packs little-endian code words into a byte
// buffer and presents a 12-byte window to the decoder, retiring instr_len bytes per issue.
module instr_fetch_seq #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000,
  parameter int          BUF_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic [95:0] raw_instr,
  input  logic [3:0]  instr_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_eip,
  input  logic        flush,
  input  logic [31:0] flush_eip,
  output logic        fault,
  output logic        done
);

  import instr_fetch_seq_pkg::*;

  if (BUF_BYTES != instr_fetch_seq_pkg::BUF_BYTES) begin : g_bad_depth
    $error("instr_fetch_seq: only a 16-byte buffer is supported");
  end

  localparam int BW = 8 * instr_fetch_seq_pkg::BUF_BYTES;

  fetch_state_e     state_q, state_d;
  logic [BW-1:0]    buf_q, buf_d, buf_shift;
  logic [CNT_W-1:0] count_q, count_d;
  logic             eos_q, eos_d;
  logic [31:0]      eip_q, eip_d;

  logic             chk_active, len_ok, bad_len, hs, acc;
  logic [CNT_W-1:0] consumed, remain;

  // Length checking only happens once a full window (or the stream tail) is buffered.
  assign chk_active = ((state_q == ST_ISSUE) && (count_q >= CNT_W'(WIN_BYTES))) ||
                      ((state_q == ST_DRAIN) && (count_q != '0));
  assign len_ok     = len_valid(instr_len, count_q);
  assign bad_len    = chk_active && !len_ok;
  assign out_valid  = chk_active && len_ok;
  assign hs         = out_valid && out_ready;
  assign consumed   = hs ? {1'b0, instr_len} : '0;
  assign remain     = count_q - consumed;
  assign in_ready   = ((state_q == ST_FILL) || (state_q == ST_ISSUE)) && !flush &&
                      (remain <= CNT_W'(WIN_BYTES));
  assign acc        = in_valid && in_ready;

  assign out_eip = eip_q;
  assign fault   = (state_q == ST_FAULT);
  assign done    = (state_q == ST_END);

  always_comb begin
    raw_instr = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (CNT_W'(k) < count_q) raw_instr[8*k +: 8] = buf_q[8*k +: 8];
    end
  end

  fetch_byte_shifter u_shifter (
    .buf_i    (buf_q),
    .shamt_i  (consumed),
    .wr_en_i  (acc),
    .wr_idx_i (remain),
    .word_i   (in_word),
    .buf_o    (buf_shift)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    eos_d   = eos_q;
    eip_d   = eip_q;
    if (flush) begin
      // Redirect wins over any handshake or word arriving in the same cycle.
      state_d = ST_FILL;
      count_d = '0;
      eos_d   = 1'b0;
      eip_d   = flush_eip;
    end else begin
      buf_d   = buf_shift;
      count_d = remain + (acc ? CNT_W'(4) : CNT_W'(0));
      eip_d   = eip_q + 32'(consumed);
      eos_d   = eos_q || (acc && in_last);
      unique case (state_q)
        ST_FILL: begin
          if (eos_d)                               state_d = ST_DRAIN;
          else if (count_d >= CNT_W'(WIN_BYTES))   state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bad_len)                             state_d = ST_FAULT;
          else if (eos_d)                          state_d = ST_DRAIN;
          else if (count_d < CNT_W'(WIN_BYTES))    state_d = ST_FILL;
        end
        ST_DRAIN: begin
          if (bad_len)                             state_d = ST_FAULT;
          else if (count_d == '0)                  state_d = ST_END;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      buf_q   <= '0;
      count_q <= '0;
      eos_q   <= 1'b0;
      eip_q   <= RESET_EIP;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      eos_q   <= eos_d;
      eip_q   <= eip_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed-vector bench for instr_fetch_seq: per-cycle stimulus table plus
// a hand-written asynchronous-reset sequence.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, flush, fault, done;
  logic [31:0] in_word, out_eip, flush_eip;
  logic [95:0] raw_instr;
  logic [3:0]  instr_len;

  always #5 clk = ~clk;

  instr_fetch_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_last   (in_last),
    .raw_instr (raw_instr),
    .instr_len (instr_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eip   (out_eip),
    .flush     (flush),
    .flush_eip (flush_eip),
    .fault     (fault),
    .done      (done)
  );

  typedef struct {
    logic        iv;
    logic [31:0] word;
    logic        last;
    logic [3:0]  len;
    logic        ordy;
    logic        fl;
    logic [31:0] feip;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_eip;
    logic [95:0] e_raw;
    logic        e_flt;
    logic        e_dn;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] W90    = 32'h9090_9090;
  localparam logic [95:0] R90_4  = 96'h0000_0000_0000_0000_9090_9090;
  localparam logic [95:0] R90_8  = 96'h0000_0000_9090_9090_9090_9090;
  localparam logic [95:0] R90_9  = 96'h0000_0090_9090_9090_9090_9090;
  localparam logic [95:0] R90_11 = 96'h0090_9090_9090_9090_9090_9090;
  localparam logic [95:0] R90_12 = 96'h9090_9090_9090_9090_9090_9090;

  function automatic void addv(input logic iv, input logic [31:0] word, input logic last,
                               input logic [3:0] len, input logic ordy, input logic fl,
                               input logic [31:0] feip, input logic e_ir, input logic e_ov,
                               input logic [31:0] e_eip, input logic [95:0] e_raw,
                               input logic e_flt, input logic e_dn);
    vec_t v;
    v.iv = iv; v.word = word; v.last = last; v.len = len; v.ordy = ordy; v.fl = fl;
    v.feip = feip; v.e_ir = e_ir; v.e_ov = e_ov; v.e_eip = e_eip; v.e_raw = e_raw;
    v.e_flt = e_flt; v.e_dn = e_dn;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic iv, input logic [31:0] word, input logic last,
                       input logic [3:0] len, input logic ordy, input logic fl,
                       input logic [31:0] feip);
    in_valid = iv; in_word = word; in_last = last; instr_len = len;
    out_ready = ordy; flush = fl; flush_eip = feip;
  endtask

  task automatic check(input string name, input logic e_ir, input logic e_ov,
                       input logic [31:0] e_eip, input logic [95:0] e_raw,
                       input logic e_flt, input logic e_dn);
    n_vec++;
    if ({in_ready, out_valid, out_eip, raw_instr, fault, done} !==
        {e_ir, e_ov, e_eip, e_raw, e_flt, e_dn}) begin
      n_err++;
      $display("FAIL %s: got ir=%b ov=%b eip=%h raw=%h fault=%b done=%b, want ir=%b ov=%b eip=%h raw=%h fault=%b done=%b",
               name, in_ready, out_valid, out_eip, raw_instr, fault, done,
               e_ir, e_ov, e_eip, e_raw, e_flt, e_dn);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // iv word          last len ordy fl feip         | ir ov eip           raw                              flt dn
    // Three NOP words, then one-byte instructions.
    addv(0, 0,            0, 1, 1, 0, 0,            1, 0, 32'h0,         96'h0,                           0, 0);
    addv(1, W90,          0, 1, 1, 0, 0,            1, 0, 32'h0,         96'h0,                           0, 0);
    addv(1, W90,          0, 1, 1, 0, 0,            1, 0, 32'h0,         R90_4,                           0, 0);
    addv(1, W90,          0, 1, 1, 0, 0,            1, 0, 32'h0,         R90_8,                           0, 0);
    addv(0, 0,            0, 1, 1, 0, 0,            1, 1, 32'h0,         R90_12,                          0, 0);
    addv(1, W90,          0, 1, 1, 0, 0,            1, 0, 32'h1,         R90_11,                          0, 0);
    addv(0, 0,            0, 1, 1, 0, 0,            0, 1, 32'h1,         R90_12,                          0, 0);
    addv(0, 0,            0, 1, 1, 0, 0,            0, 1, 32'h2,         R90_12,                          0, 0);
    addv(0, 0,            0, 1, 1, 0, 0,            1, 1, 32'h3,         R90_12,                          0, 0);
    // Flush during ISSUE.
    addv(0, 0,            0, 1, 1, 1, 32'h0804_8000, 0, 1, 32'h4,        R90_12,                          0, 0);
    addv(0, 0,            0, 5, 0, 0, 0,            1, 0, 32'h0804_8000, 96'h0,                           0, 0);
    // Fill to 16 bytes, then handshake len 5 together with a word accept.
    addv(1, 32'h0302_0100, 0, 5, 0, 0, 0,           1, 0, 32'h0804_8000, 96'h0,                           0, 0);
    addv(1, 32'h0706_0504, 0, 5, 0, 0, 0,           1, 0, 32'h0804_8000, 96'h0302_0100,                   0, 0);
    addv(1, 32'h0B0A_0908, 0, 5, 0, 0, 0,           1, 0, 32'h0804_8000, 96'h0706_0504_0302_0100,         0, 0);
    addv(1, 32'h0F0E_0D0C, 0, 5, 0, 0, 0,           1, 1, 32'h0804_8000, 96'h0B0A_0908_0706_0504_0302_0100, 0, 0);
    addv(1, 32'h1312_1110, 0, 5, 1, 0, 0,           1, 1, 32'h0804_8000, 96'h0B0A_0908_0706_0504_0302_0100, 0, 0);
    addv(0, 0,            0, 5, 0, 0, 0,            0, 1, 32'h0804_8005, 96'h100F_0E0D_0C0B_0A09_0807_0605, 0, 0);
    addv(0, 0,            0, 4, 1, 0, 0,            1, 1, 32'h0804_8005, 96'h100F_0E0D_0C0B_0A09_0807_0605, 0, 0);
    addv(0, 0,            0, 4, 0, 0, 0,            1, 0, 32'h0804_8009, 96'h0013_1211_100F_0E0D_0C0B_0A09, 0, 0);
    // EIP wrap-around.
    addv(0, 0,            0, 4, 0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0804_8009, 96'h0013_1211_100F_0E0D_0C0B_0A09, 0, 0);
    addv(1, W90,          0, 3, 1, 0, 0,            1, 0, 32'hFFFF_FFFE, 96'h0,                           0, 0);
    addv(1, W90,          0, 3, 1, 0, 0,            1, 0, 32'hFFFF_FFFE, R90_4,                           0, 0);
    addv(1, W90,          0, 3, 1, 0, 0,            1, 0, 32'hFFFF_FFFE, R90_8,                           0, 0);
    addv(0, 0,            0, 3, 1, 0, 0,            1, 1, 32'hFFFF_FFFE, R90_12,                          0, 0);
    addv(0, 0,            0, 3, 0, 0, 0,            1, 0, 32'h0000_0001, R90_9,                           0, 0);
    // Short stream: one 5-byte instruction, then an over-long length faults.
    addv(0, 0,            0, 3, 0, 1, 32'h0,        0, 0, 32'h0000_0001, R90_9,                           0, 0);
    addv(1, 32'h0000_01B8, 0, 5, 1, 0, 0,           1, 0, 32'h0,         96'h0,                           0, 0);
    addv(1, 32'h0000_0000, 1, 5, 1, 0, 0,           1, 0, 32'h0,         96'h0000_01B8,                   0, 0);
    addv(0, 0,            0, 5, 1, 0, 0,            0, 1, 32'h0,         96'h0000_01B8,                   0, 0);
    addv(0, 0,            0, 4, 1, 0, 0,            0, 0, 32'h5,         96'h0,                           0, 0);
    addv(0, 0,            0, 4, 1, 0, 0,            0, 0, 32'h5,         96'h0,                           1, 0);
    addv(0, 0,            0, 1, 1, 0, 0,            0, 0, 32'h5,         96'h0,                           1, 0);
    addv(0, 0,            0, 1, 1, 1, 32'h100,      0, 0, 32'h5,         96'h0,                           1, 0);
    addv(0, 0,            0, 1, 0, 0, 0,            1, 0, 32'h100,       96'h0,                           0, 0);
    // One-word stream runs to END; words are refused there until a flush.
    addv(1, 32'h4433_2211, 1, 4, 1, 0, 0,           1, 0, 32'h100,       96'h0,                           0, 0);
    addv(0, 0,            0, 4, 1, 0, 0,            0, 1, 32'h100,       96'h4433_2211,                   0, 0);
    addv(1, 32'h5555_5555, 0, 4, 1, 0, 0,           0, 0, 32'h104,       96'h0,                           0, 1);
    addv(0, 0,            0, 4, 1, 1, 32'h0,        0, 0, 32'h104,       96'h0,                           0, 1);
    addv(0, 0,            0, 4, 1, 0, 0,            1, 0, 32'h0,         96'h0,                           0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].word, vecs[i].last, vecs[i].len, vecs[i].ordy,
            vecs[i].fl, vecs[i].feip);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_eip,
            vecs[i].e_raw, vecs[i].e_flt, vecs[i].e_dn);
    end

    // Asynchronous reset in the middle of a cycle with a handshake and a word pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, W90, 0, 2, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 2, 1, 0, 0);
    @(negedge clk);
    drive(1, W90, 0, 2, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'hA5A5_A5A5, 0, 3, 1, 0, 0);
    #1;
    check("pre_rst", 1, 1, 32'h2, R90_12, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", 1, 0, 32'h0, 96'h0, 0, 0);
    drive(0, 0, 0, 2, 0, 0, 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst", 1, 0, 32'h0, 96'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
